multdiv_ctrl: RTL and testbench
===============================

// Module: multdiv_ctrl
// PURPOSE
//  Sequencer for the iterative multiply/divide datapath built from 32-bit falling-edge register banks.
//  Accepts single-cycle start pulses and drives the bank enables and clears:
//  operand load, product/remainder accumulate, and quotient shift.
//  Counts iterations and flags divide-by-zero, then returns a one-cycle result-ready pulse
//  plus a stall to the pipeline. Sits between decode/execute and the multdiv datapath.
// PARAMETERS
//  MULT_CYCLES  32  RUN-state iterations for a multiply (radix-2 shift-add)
//  DIV_CYCLES   32  RUN-state iterations for a divide (restoring)
//  CNT_W        6   iteration counter width; must satisfy 2**CNT_W > max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk             in   1      system clock; FSM is rising-edge, datapath banks capture on falling edge
//  reset           in   1      asynchronous, active-low reset
//  ctrl_MULT       in   1      start multiply; sampled on rising edge, single-cycle pulse
//  ctrl_DIV        in   1      start divide; sampled on rising edge, single-cycle pulse
//  divisor_zero    in   1      datapath flag: operand B == 0; valid during LOAD
//  ld_operands     out  1      enable for operand A/B banks
//  acc_clr         out  1      clear for product/remainder bank
//  acc_en          out  1      enable for product/remainder bank
//  shift_en        out  1      enable for multiplier/quotient shift bank
//  op_is_div       out  1      mux select: 1 = divide datapath, 0 = multiply
//  count           out  CNT_W  current iteration index, 0-based
//  busy            out  1      operation in progress; drives pipeline stall
//  data_resultRDY  out  1      one-cycle pulse: result valid in datapath banks
//  data_exception  out  1      valid only with data_resultRDY: div-by-zero or illegal start
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, count=0, op_is_div=0, every output 0.
//    Any operation in flight is abandoned, with no resultRDY.
//  - All outputs are Moore (decoded from registered state/count), stable from rising edge,
//    so the falling-edge banks capture them glitch-free at mid-cycle.
//  - States and transitions:
//    IDLE: all enables 0, busy=0. A start pulse goes to LOAD and latches op_is_div (DIV=1).
//    LOAD (1 cycle): ld_operands=1, acc_clr=1, busy=1, count=0.
//      - divide with divisor_zero=1 -> DONE with exc flag set
//      - otherwise -> RUN
//    RUN: acc_en=1, shift_en=1, busy=1; count increments each cycle.
//      Leaves to DONE on the cycle count==N-1 (N = MULT_CYCLES or DIV_CYCLES); count then resets to 0.
//    DONE (1 cycle): data_resultRDY=1, busy=0, data_exception=exc flag; goes to IDLE,
//      or straight to LOAD if a start pulse arrives that cycle.
//  - Latency: start sampled at edge E0 -> LOAD in E0..E0+1 -> RUN for N cycles
//    -> resultRDY high from edge E0+N+1 to E0+N+2.
//    Divide-by-zero: resultRDY at E0+1..E0+2, with exception=1.
//  - Simultaneous ctrl_MULT and ctrl_DIV: illegal. Go to DONE with exception=1,
//    with no LOAD or RUN and no datapath enables asserted.
//  - Start while busy (LOAD/RUN): abort the current operation and restart in LOAD
//    with the new op; no resultRDY is issued for the aborted op.
//  - count never wraps: it saturates at its exit value and is cleared on entry to LOAD and DONE.
//  - acc_en/shift_en are never asserted outside RUN; ld_operands never outside LOAD.
//  - exc flag clears on entry to LOAD and in IDLE; data_exception=0 whenever resultRDY=0.
// TESTING
//  1) Reset asserted mid-RUN (count=10) -> all outputs 0 within same cycle, IDLE, no resultRDY afterward.
//  2) ctrl_MULT pulse at E0 -> ld_operands at E0..+1, acc_en for 32 cycles, count 0..31,
//     resultRDY at E0+33 for exactly 1 cycle, exception=0.
//  3) ctrl_DIV with divisor_zero=1 -> no acc_en, resultRDY=1 & exception=1 at E0+1..E0+2.
//  4) ctrl_MULT and ctrl_DIV in same cycle -> DONE next cycle, resultRDY=1, exception=1, ld_operands never 1.
//  5) ctrl_DIV at count=15 of a multiply -> re-enter LOAD, op_is_div=1,
//     single resultRDY 34 cycles after the second pulse.
//  6) Start pulse in DONE cycle -> back-to-back ops, LOAD immediately after DONE, busy low for that one cycle only.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
// Sequencer for the iterative multiply/divide datapath. Takes single-cycle
// start pulses from decode/execute and steps the falling-edge register banks
// through LOAD -> RUN (N iterations) -> DONE. It then returns a one-cycle
// result-ready pulse and holds a stall to the pipeline while an op is in flight.
//
// Ports
//   clk            rising-edge FSM clock (datapath banks capture on falling edge)
//   reset          asynchronous, active-low reset
//   ctrl_MULT      start multiply (single-cycle pulse)
//   ctrl_DIV       start divide (single-cycle pulse)
//   divisor_zero   datapath flag, operand B == 0, valid during LOAD
//   ld_operands    operand A/B bank enable (LOAD only)
//   acc_clr        product/remainder bank clear (LOAD only)
//   acc_en         product/remainder bank enable (RUN only)
//   shift_en       multiplier/quotient shift enable (RUN only)
//   op_is_div      datapath mux select, 1 = divide
//   count          current iteration index, 0-based
//   busy           operation in progress (pipeline stall)
//   data_resultRDY one-cycle result-valid pulse
//   data_exception divide-by-zero or illegal start, qualified by data_resultRDY
//
// Every output is a flop loaded from the next-state decode. This keeps the
// outputs stable from the rising edge, so the falling-edge banks sample them
// cleanly at mid-cycle.
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    output logic             ld_operands,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             shift_en,
    output logic             op_is_div,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             op_div_r, op_div_s;
    logic             exc_r, exc_s;
    logic             start_s, illegal_s, last_s;

    logic             ld_operands_r, acc_clr_r, acc_en_r, shift_en_r;
    logic             busy_r, rdy_r, exc_out_r;

    // Next-state, counter, op-select and exception-flag logic
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        op_div_s  = op_div_r;
        exc_s     = exc_r;
        // Both starts together is illegal; exactly one is a legal start
        illegal_s = ctrl_MULT & ctrl_DIV;
        start_s   = ctrl_MULT ^ ctrl_DIV;
        if (op_div_r) begin
            last_s = (count_r == DIV_LAST);
        end else begin
            last_s = (count_r == MULT_LAST);
        end

        if (illegal_s) begin
            // Report straight away without touching the datapath
            state_s = ST_DONE;
            count_s = CNT_ZERO;
            exc_s   = 1'b1;
        end else if (start_s) begin
            // A start in any state, including mid-operation, restarts in LOAD
            state_s  = ST_LOAD;
            count_s  = CNT_ZERO;
            op_div_s = ctrl_DIV;
            exc_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_s = CNT_ZERO;
                    exc_s   = 1'b0;
                end
                ST_LOAD: begin
                    count_s = CNT_ZERO;
                    if (op_div_r && divisor_zero) begin
                        state_s = ST_DONE;
                        exc_s   = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        state_s = ST_DONE;
                        count_s = CNT_ZERO;
                    end else begin
                        count_s = count_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    count_s = CNT_ZERO;
                    exc_s   = 1'b0;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = CNT_ZERO;
                    exc_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            op_div_r <= 1'b0;
            exc_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            op_div_r <= op_div_s;
            exc_r    <= exc_s;
        end
    end

    // Output flops, loaded with the decode of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_operands_r <= 1'b0;
            acc_clr_r     <= 1'b0;
            acc_en_r      <= 1'b0;
            shift_en_r    <= 1'b0;
            busy_r        <= 1'b0;
            rdy_r         <= 1'b0;
            exc_out_r     <= 1'b0;
        end else begin
            ld_operands_r <= (state_s == ST_LOAD);
            acc_clr_r     <= (state_s == ST_LOAD);
            acc_en_r      <= (state_s == ST_RUN);
            shift_en_r    <= (state_s == ST_RUN);
            busy_r        <= (state_s == ST_LOAD) || (state_s == ST_RUN);
            rdy_r         <= (state_s == ST_DONE);
            exc_out_r     <= (state_s == ST_DONE) && exc_s;
        end
    end

    assign ld_operands    = ld_operands_r;
    assign acc_clr        = acc_clr_r;
    assign acc_en         = acc_en_r;
    assign shift_en       = shift_en_r;
    assign op_is_div      = op_div_r;
    assign count          = count_r;
    assign busy           = busy_r;
    assign data_resultRDY = rdy_r;
    assign data_exception = exc_out_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

    logic       clk;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       divisor_zero;
    logic       ld_operands;
    logic       acc_clr;
    logic       acc_en;
    logic       shift_en;
    logic       op_is_div;
    logic [5:0] count;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;

    int checks;
    int errors;

    // {ld_operands, acc_clr, acc_en, shift_en, busy, resultRDY, exception}
    logic [6:0] outs;
    assign outs = {ld_operands, acc_clr, acc_en, shift_en, busy, data_resultRDY, data_exception};

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LOAD  = 7'b1100100;
    localparam logic [6:0] O_RUN   = 7'b0011100;
    localparam logic [6:0] O_DONE  = 7'b0000010;
    localparam logic [6:0] O_DONEX = 7'b0000011;

    multdiv_ctrl #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
        .ld_operands    (ld_operands),
        .acc_clr        (acc_clr),
        .acc_en         (acc_en),
        .shift_en       (shift_en),
        .op_is_div      (op_is_div),
        .count          (count),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns observing the state entered at that edge
    task automatic pulse(input logic m, input logic d);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== O_IDLE || count !== 6'd0 || op_is_div !== 1'b0) begin
            errors++;
            $display("FAIL reset_state outs=%b count=%0d div=%b expected outs=%b count=0 div=0",
                     outs, count, op_is_div, O_IDLE);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset outs=%b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_mult();
        int run_cycles;
        run_cycles = 0;
        pulse(1'b1, 1'b0);
        checks++;
        if (outs !== O_LOAD || count !== 6'd0 || op_is_div !== 1'b0) begin
            errors++;
            $display("FAIL mult_load outs=%b count=%0d div=%b expected outs=%b count=0 div=0",
                     outs, count, op_is_div, O_LOAD);
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            if (acc_en === 1'b1) run_cycles++;
            checks++;
            if (outs !== O_RUN || count !== 6'(i)) begin
                errors++;
                $display("FAIL mult_run[%0d] outs=%b count=%0d expected outs=%b count=%0d",
                         i, outs, count, O_RUN, i);
            end
        end
        checks++;
        if (run_cycles != 32) begin
            errors++;
            $display("FAIL mult_acc_cycles got %0d expected 32", run_cycles);
        end
        tick();
        checks++;
        if (outs !== O_DONE || count !== 6'd0) begin
            errors++;
            $display("FAIL mult_done outs=%b count=%0d expected outs=%b count=0", outs, count, O_DONE);
        end
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL mult_rdy_one_cycle outs=%b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_mult_ignores_dz();
        divisor_zero = 1'b1;
        pulse(1'b1, 1'b0);
        tick();
        checks++;
        if (outs !== O_RUN) begin
            errors++;
            $display("FAIL mult_dz_run outs=%b expected %b", outs, O_RUN);
        end
        divisor_zero = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        checks++;
        if (outs !== O_DONE) begin
            errors++;
            $display("FAIL mult_dz_done outs=%b expected %b", outs, O_DONE);
        end
        tick();
    endtask

    task automatic test_div_zero();
        divisor_zero = 1'b1;
        pulse(1'b0, 1'b1);
        checks++;
        if (outs !== O_LOAD || op_is_div !== 1'b1) begin
            errors++;
            $display("FAIL div0_load outs=%b div=%b expected outs=%b div=1", outs, op_is_div, O_LOAD);
        end
        tick();
        divisor_zero = 1'b0;
        checks++;
        if (outs !== O_DONEX || count !== 6'd0) begin
            errors++;
            $display("FAIL div0_done outs=%b count=%0d expected outs=%b count=0", outs, count, O_DONEX);
        end
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL div0_idle outs=%b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_illegal();
        pulse(1'b1, 1'b1);
        checks++;
        if (outs !== O_DONEX) begin
            errors++;
            $display("FAIL illegal_done outs=%b expected %b", outs, O_DONEX);
        end
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL illegal_idle outs=%b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_abort();
        int first_rdy;
        int rdy_pulses;
        first_rdy  = -1;
        rdy_pulses = 0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (outs !== O_RUN || count !== 6'd15) begin
            errors++;
            $display("FAIL abort_pre outs=%b count=%0d expected outs=%b count=15", outs, count, O_RUN);
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (outs !== O_LOAD || op_is_div !== 1'b1 || count !== 6'd0) begin
            errors++;
            $display("FAIL abort_reload outs=%b div=%b count=%0d expected outs=%b div=1 count=0",
                     outs, op_is_div, count, O_LOAD);
        end
        // pulse cycle + 33 further edges = 34 cycles to the result
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (data_resultRDY === 1'b1) begin
                rdy_pulses++;
                if (first_rdy < 0) first_rdy = i;
            end
        end
        checks++;
        if (first_rdy != 33 || rdy_pulses != 1) begin
            errors++;
            $display("FAIL abort_result first=%0d pulses=%0d expected first=33 pulses=1",
                     first_rdy, rdy_pulses);
        end
    endtask

    task automatic test_back_to_back();
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 33; i++) tick();
        checks++;
        if (outs !== O_DONE) begin
            errors++;
            $display("FAIL b2b_first_done outs=%b expected %b", outs, O_DONE);
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (outs !== O_LOAD || op_is_div !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reload outs=%b div=%b expected outs=%b div=1", outs, op_is_div, O_LOAD);
        end
        for (int i = 0; i < 33; i++) tick();
        checks++;
        if (outs !== O_DONE) begin
            errors++;
            $display("FAIL b2b_second_done outs=%b expected %b", outs, O_DONE);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int rdy_seen;
        rdy_seen = 0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (outs !== O_RUN || count !== 6'd10) begin
            errors++;
            $display("FAIL rst_mid_pre outs=%b count=%0d expected outs=%b count=10", outs, count, O_RUN);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE || count !== 6'd0 || op_is_div !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async outs=%b count=%0d div=%b expected all zero", outs, count, op_is_div);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_seen++;
        end
        checks++;
        if (rdy_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet activity_cycles=%0d expected 0", rdy_seen);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b0;
        test_reset();
        test_mult();
        test_mult_ignores_dz();
        test_div_zero();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
